alu_seq_exec: RTL and testbench

//  Execute-stage ALU consuming the 4-bit alu_sel code produced by the ALU control decoder.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_shift_step.sv | 28 ++
 rtl/alu_seq_exec.sv | 135 +++++++++++++
 tb/tb_alu_seq_exec.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with the ALU control decoder),
// default datapath width and execute-stage FSM state encodings.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational partial shifter: moves data by amt_i positions left or right,
// filling vacated high bits with fill_i on right shifts.
module alu_shift_step #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 6
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [AW-1:0]   amt_i,
    input  logic            left_i,
    input  logic            fill_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] fill_mask;

    always_comb begin
        fill_mask = '0;
        if (fill_i) begin
            fill_mask = ~({XLEN{1'b1}} >> amt_i);
        end
        if (left_i) begin
            data_o = data_i << amt_i;
        end else begin
            data_o = (data_i >> amt_i) | fill_mask;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, iterative shifts of
// SHIFT_STEP bits per cycle, valid/ready handshakes on input and output.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_sel,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            left_q, left_d;
    logic            fill_q, fill_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic [CW-1:0]   shamt;
    logic [CW-1:0]   step;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] alu_res;

    assign shamt = {1'b0, op_b[SHW-1:0]};
    assign step  = (rem_q > STEP_C) ? STEP_C : rem_q;

    alu_shift_step #(
        .XLEN (XLEN),
        .AW   (CW)
    ) u_shift (
        .data_i (shreg_q),
        .amt_i  (step),
        .left_i (left_q),
        .fill_i (fill_q),
        .data_o (shifted)
    );

    // Shift codes only reach this mux with a zero shift amount, so they pass op_a.
    always_comb begin
        alu_res = op_a + op_b;
        case (alu_sel)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            default:  alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        rem_d    = rem_q;
        left_d   = left_q;
        fill_d   = fill_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift(alu_sel) && (shamt != '0)) begin
                        shreg_d = op_a;
                        rem_d   = shamt;
                        left_d  = (alu_sel == ALU_SLL);
                        fill_d  = (alu_sel == ALU_SRA) && op_a[XLEN-1];
                        state_d = StShift;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                shreg_d = shifted;
                rem_d   = rem_q - step;
                if (rem_q == step) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            fill_q   <= fill_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed and random checks of alu_seq_exec at SHIFT_STEP 1, 4 and 32 against
// a reference model, with expected results queued at issue and popped on output.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  alu_sel = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_ready = 1'b1;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [31:0] result    [3];
    logic        zero      [3];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid[0]),
        .out_ready(out_ready), .result(result[0]), .zero(zero[0])
    );
    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid[1]),
        .out_ready(out_ready), .result(result[1]), .zero(zero[1])
    );
    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(32)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid[2]),
        .out_ready(out_ready), .result(result[2]), .zero(zero[2])
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (s)
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << sh;
            4'd8: return a >> sh;
            4'd9: return $unsigned($signed(a) >>> sh);
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] s, input logic [31:0] b, input int stp);
        int sh;
        sh = int'(b[4:0]);
        if ((s >= 4'd7) && (s <= 4'd9) && (sh != 0)) return 1 + (sh + stp - 1) / stp;
        return 1;
    endfunction

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 4 : 32);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one op into DUT d for one accept edge and queues its expected outcome.
    task automatic start_op(input int d, input logic [3:0] s, input logic [31:0] a,
                            input logic [31:0] b);
        exp_t e;
        e.res = ref_alu(s, a, b);
        e.z   = (e.res == 32'd0);
        e.lat = ref_lat(s, b, step_of(d));
        sb_q.push_back(e);
        alu_sel = s;
        op_a = a;
        op_b = b;
        in_valid[d] = 1'b1;
        check("in_ready_before_accept", {31'd0, in_ready[d]}, 32'd1);
        cyc();
        in_valid[d] = 1'b0;
    endtask

    task automatic finish_op(input int d, input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            cyc();
            lat++;
        end
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_result"}, result[d], e.res);
            check({tag, "_zero"}, {31'd0, zero[d]}, {31'd0, e.z});
        end
        cyc();
        check({tag, "_in_ready_after"}, {31'd0, in_ready[d]}, 32'd1);
        check({tag, "_out_valid_after"}, {31'd0, out_valid[d]}, 32'd0);
    endtask

    task automatic do_op(input int d, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        start_op(d, s, a, b);
        finish_op(d, tag);
    endtask

    initial begin
        logic [31:0] held_res;
        logic        held_z;
        exp_t        e;
        for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;

        cyc();
        cyc();
        rst = 1'b0;
        check("reset_out_valid", {31'd0, out_valid[0]}, 32'd0);
        check("reset_result", result[0], 32'd0);
        check("reset_zero", {31'd0, zero[0]}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready[0]}, 32'd1);

        do_op(0, 4'd0, 32'd5, 32'd7, "add_5_7");
        do_op(0, 4'd1, 32'd3, 32'd3, "sub_3_3");
        do_op(0, 4'd5, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        do_op(0, 4'd6, 32'hFFFF_FFFF, 32'd1, "sltu_big");
        do_op(0, 4'd9, 32'h8000_0000, 32'd31, "sra_31");
        do_op(0, 4'd8, 32'hF0F0_1234, 32'h25, "srl_5");
        do_op(0, 4'd7, 32'hDEAD_BEEF, 32'd0, "sll_0");
        do_op(0, 4'd15, 32'd1, 32'd2, "sel15_add");

        // Reset while a 31-step shift is in flight discards it.
        alu_sel = 4'd9;
        op_a = 32'h8000_0000;
        op_b = 32'd31;
        in_valid[0] = 1'b1;
        cyc();
        in_valid[0] = 1'b0;
        repeat (9) cyc();
        check("midshift_no_valid", {31'd0, out_valid[0]}, 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midshift_rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
        check("midshift_rst_result", result[0], 32'd0);
        check("midshift_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
        repeat (35) cyc();
        check("midshift_discarded", {31'd0, out_valid[0]}, 32'd0);
        do_op(0, 4'd0, 32'd100, 32'd23, "add_after_rst");

        // Backpressure: hold result in DONE while in_valid is ignored.
        out_ready = 1'b0;
        start_op(0, 4'd1, 32'd9, 32'd9);
        check("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
        e = sb_q.pop_front();
        check("bp_result", result[0], e.res);
        check("bp_zero", {31'd0, zero[0]}, {31'd0, e.z});
        held_res = e.res;
        held_z = e.z;
        alu_sel = 4'd0;
        op_a = 32'd1;
        op_b = 32'd1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_hold_result", result[0], held_res);
            check("bp_hold_zero", {31'd0, zero[0]}, {31'd0, held_z});
            check("bp_hold_in_ready", {31'd0, in_ready[0]}, 32'd0);
            check("bp_hold_out_valid", {31'd0, out_valid[0]}, 32'd1);
        end
        in_valid[0] = 1'b0;
        out_ready = 1'b1;
        cyc();
        check("bp_release_out_valid", {31'd0, out_valid[0]}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready[0]}, 32'd1);
        cyc();
        check("bp_ignored_input", {31'd0, out_valid[0]}, 32'd0);

        // Random ops on each shift step width.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [3:0]  s;
                logic [31:0] a;
                logic [31:0] b;
                s = 4'($urandom_range(0, 15));
                a = $urandom;
                b = $urandom;
                if (i % 5 == 0) a = {1'b1, a[30:0]};
                if (i % 7 == 0) b = a;
                do_op(d, s, a, b, $sformatf("rand_d%0d_sel%0d", d, s));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
